// File: rtl/ds18b20_pkg.sv
// Shared constants, state encoding and CRC helper for the DS18B20 read sequencer.
package ds18b20_pkg;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;
    localparam int         SP_BYTES     = 9;
    localparam logic [7:0] CRC_POLY_REF = 8'h8C;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_RST   = 4'd1;
    localparam state_t S_RST_W = 4'd2;
    localparam state_t S_CMD   = 4'd3;
    localparam state_t S_CMD_W = 4'd4;
    localparam state_t S_CONV  = 4'd5;
    localparam state_t S_RD    = 4'd6;
    localparam state_t S_RD_W  = 4'd7;
    localparam state_t S_CHK   = 4'd8;
    localparam state_t S_FIN   = 4'd9;

    // Dallas/Maxim CRC8, bits consumed LSB first as they come off the wire.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REF;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Two commands per phase: Skip ROM, then Convert T (phase 0) or Read Scratchpad (phase 1).
    function automatic logic [7:0] cmd_byte(input logic phase, input logic idx);
        if (!idx) return CMD_SKIP_ROM;
        return phase ? CMD_READ_SP : CMD_CONVERT;
    endfunction

endpackage

// File: rtl/ds18b20_crc8.sv
// Byte-wide Dallas CRC8 accumulator with registered output.
module ds18b20_crc8 import ds18b20_pkg::*; (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_reg;

    always_ff @(posedge clk) begin
        if (!arst_n || clr) crc_reg <= '0;
        else if (en)        crc_reg <= crc8_byte(crc_reg, data);
    end

    assign crc = crc_reg;

endmodule

// File: rtl/ds18b20_reader.sv
// Runs one DS18B20 convert + scratchpad read per start pulse through a onewire_master.
module ds18b20_reader import ds18b20_pkg::*; #(
    parameter int CONV_CYC  = 1_500_000,
    parameter int XFER_TO   = 4_000,
    parameter int RST_PULSE = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic        crc_err,
    output logic        to_err,
    output logic        owm_rst_n,
    output logic [3:0]  owm_bits,
    output logic [7:0]  owm_wdat,
    output logic        owm_we,
    output logic        owm_vld,
    input  logic        owm_rdy,
    input  logic [7:0]  owm_rdat
);

    localparam int CONV_W = $clog2(CONV_CYC + 1);
    localparam int TMO_W  = $clog2(XFER_TO + 1);
    localparam int PUL_W  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    state_t            state_reg;
    logic              phase_reg;
    logic              idx_reg;
    logic [1:0]        skip_reg;
    logic [PUL_W-1:0]  pulse_reg;
    logic [CONV_W-1:0] conv_reg;
    logic [TMO_W-1:0]  tmo_reg;
    logic [3:0]        nbyte_reg;
    logic [7:0]        byte0_reg;
    logic [7:0]        byte1_reg;
    logic [15:0]       temp_reg;
    logic              temp_vld_reg;
    logic              crc_err_reg;
    logic              to_err_reg;
    logic              owm_rst_n_reg;
    logic              owm_vld_reg;
    logic              owm_we_reg;
    logic [7:0]        owm_wdat_reg;

    logic       in_wait;
    logic       wait_ok;
    logic       wait_to;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc_val;

    // Master rdy is not trusted for the first two cycles after a request.
    assign in_wait = (state_reg == S_RST_W) || (state_reg == S_CMD_W) || (state_reg == S_RD_W);
    assign wait_ok = in_wait && (skip_reg == 2'd0) && owm_rdy;
    assign wait_to = in_wait && (skip_reg == 2'd0) && !owm_rdy && (tmo_reg == '0);
    assign crc_clr = (state_reg == S_IDLE) && start;
    assign crc_en  = (state_reg == S_RD_W) && wait_ok;

    ds18b20_crc8 u_crc (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .data   (owm_rdat),
        .crc    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_reg     <= S_IDLE;
            phase_reg     <= 1'b0;
            idx_reg       <= 1'b0;
            skip_reg      <= 2'd0;
            pulse_reg     <= '0;
            conv_reg      <= '0;
            tmo_reg       <= '0;
            nbyte_reg     <= 4'd0;
            byte0_reg     <= 8'h00;
            byte1_reg     <= 8'h00;
            temp_reg      <= 16'h0000;
            temp_vld_reg  <= 1'b0;
            crc_err_reg   <= 1'b0;
            to_err_reg    <= 1'b0;
            owm_rst_n_reg <= 1'b1;
            owm_vld_reg   <= 1'b0;
            owm_we_reg    <= 1'b0;
            owm_wdat_reg  <= 8'h00;
        end else begin
            owm_vld_reg <= 1'b0;
            if (in_wait) begin
                if (skip_reg != 2'd0) skip_reg <= skip_reg - 2'd1;
                if (tmo_reg != '0)    tmo_reg  <= tmo_reg - TMO_W'(1);
            end
            case (state_reg)
                S_IDLE: if (start) begin
                    crc_err_reg   <= 1'b0;
                    to_err_reg    <= 1'b0;
                    phase_reg     <= 1'b0;
                    idx_reg       <= 1'b0;
                    owm_rst_n_reg <= 1'b0;
                    pulse_reg     <= PUL_W'(RST_PULSE - 1);
                    tmo_reg       <= TMO_W'(XFER_TO);
                    state_reg     <= S_RST;
                end
                S_RST: if (pulse_reg == '0) begin
                    owm_rst_n_reg <= 1'b1;
                    skip_reg      <= 2'd2;
                    state_reg     <= S_RST_W;
                end else begin
                    pulse_reg <= pulse_reg - PUL_W'(1);
                end
                S_RST_W: if (wait_ok) begin
                    state_reg <= S_CMD;
                end else if (wait_to) begin
                    to_err_reg <= 1'b1;
                    state_reg  <= S_FIN;
                end
                S_CMD: begin
                    owm_vld_reg  <= 1'b1;
                    owm_we_reg   <= 1'b1;
                    owm_wdat_reg <= cmd_byte(phase_reg, idx_reg);
                    skip_reg     <= 2'd2;
                    tmo_reg      <= TMO_W'(XFER_TO);
                    state_reg    <= S_CMD_W;
                end
                S_CMD_W: if (wait_ok) begin
                    if (!idx_reg) begin
                        idx_reg   <= 1'b1;
                        state_reg <= S_CMD;
                    end else if (!phase_reg) begin
                        conv_reg  <= CONV_W'(CONV_CYC - 1);
                        state_reg <= S_CONV;
                    end else begin
                        nbyte_reg <= 4'd0;
                        state_reg <= S_RD;
                    end
                end else if (wait_to) begin
                    to_err_reg <= 1'b1;
                    state_reg  <= S_FIN;
                end
                S_CONV: if (conv_reg == '0) begin
                    phase_reg     <= 1'b1;
                    idx_reg       <= 1'b0;
                    owm_rst_n_reg <= 1'b0;
                    pulse_reg     <= PUL_W'(RST_PULSE - 1);
                    tmo_reg       <= TMO_W'(XFER_TO);
                    state_reg     <= S_RST;
                end else begin
                    conv_reg <= conv_reg - CONV_W'(1);
                end
                S_RD: begin
                    owm_vld_reg <= 1'b1;
                    owm_we_reg  <= 1'b0;
                    skip_reg    <= 2'd2;
                    tmo_reg     <= TMO_W'(XFER_TO);
                    state_reg   <= S_RD_W;
                end
                S_RD_W: if (wait_ok) begin
                    if (nbyte_reg == 4'd0) byte0_reg <= owm_rdat;
                    if (nbyte_reg == 4'd1) byte1_reg <= owm_rdat;
                    if (nbyte_reg != 4'(SP_BYTES)) nbyte_reg <= nbyte_reg + 4'd1;
                    state_reg <= (nbyte_reg == 4'(SP_BYTES - 1)) ? S_CHK : S_RD;
                end else if (wait_to) begin
                    to_err_reg <= 1'b1;
                    state_reg  <= S_FIN;
                end
                S_CHK: begin
                    // A correct CRC byte appended to the data drives the residue to zero.
                    if (crc_val == 8'h00) begin
                        temp_reg     <= {byte1_reg, byte0_reg};
                        temp_vld_reg <= 1'b1;
                    end else begin
                        crc_err_reg <= 1'b1;
                    end
                    state_reg <= S_FIN;
                end
                S_FIN:   state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done      = (state_reg == S_FIN);
    assign temp      = temp_reg;
    assign temp_vld  = temp_vld_reg;
    assign crc_err   = crc_err_reg;
    assign to_err    = to_err_reg;
    assign owm_rst_n = owm_rst_n_reg;
    assign owm_bits  = 4'd8;
    assign owm_wdat  = owm_wdat_reg;
    assign owm_we    = owm_we_reg;
    assign owm_vld   = owm_vld_reg;

endmodule

// File: doc/ds18b20_reader.md
Name: ds18b20_reader

Overview:
Upstream command sequencer for onewire_master; runs one complete DS18B20 temperature read per start pulse. Issues bus reset, Skip ROM (0xCC), Convert T (0x44), waits for conversion, then reset, Skip ROM, Read Scratchpad (0xBE). Reads 9 scratchpad bytes, checks the Dallas CRC8 and presents the 16-bit raw temperature to the fabric or host register layer.

Parameters:
CONV_CYC, 1_500_000, clk cycles to wait after Convert T (750 ms at 2 MHz).
XFER_TO, 4_000, clk cycles allowed per master transaction before timeout.
RST_PULSE, 2, clk cycles owm_rst_n is held low to request a bus reset.

Ports:
clk  in  1  clock
arst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle request; ignored while busy
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of sequence (success or error)
temp  out  16  raw scratchpad bytes {byte1,byte0}; updated only on CRC pass
temp_vld  out  1  sticky; set on first CRC pass
crc_err  out  1  valid with done; CRC over 9 bytes nonzero
to_err  out  1  valid with done; a master transaction exceeded XFER_TO
owm_rst_n  out  1  bus-reset request; top-level ANDs it into the master's arst_n
owm_bits  out  4  bits per transaction, always 8
owm_wdat  out  8  command byte
owm_we  out  1  1 = write, 0 = read
owm_vld  out  1  one-cycle transaction request
owm_rdy  in  1  master ready; low while a transaction or reset/presence runs
owm_rdat  in  8  read byte, valid when owm_rdy returns high after a read

Behaviour:
- Reset values: busy 0, done 0, temp 0, temp_vld 0, crc_err 0, to_err 0, owm_rst_n 1, owm_vld 0, owm_we 0, owm_wdat 0, owm_bits 8.
- Master contract: owm_rdy goes low no later than 2 cycles after owm_vld or owm_rst_n low. It returns high when the transaction is finished.
- Each wait on owm_rdy first skips 2 cycles. It then polls owm_rdy; completion is the first cycle owm_rdy=1.
- A shared timeout counter reloads on every owm_vld or reset request and decrements each waiting cycle.
- Reaching 0 before owm_rdy=1 sets to_err and jumps to FIN.
- FSM states and transitions:
  - IDLE: start -> RST.
  - RST: owm_rst_n low for RST_PULSE cycles -> RST_W.
  - RST_W: owm_rdy -> CMD.
  - CMD: issue cmd[idx] from a 2-entry list per phase (phase 0: CC,44; phase 1: CC,BE) -> CMD_W.
  - CMD_W: owm_rdy -> next cmd or phase exit. Phase 0 exits to CONV; phase 1 exits to RD.
  - CONV: count CONV_CYC cycles -> RST with phase=1.
  - RD: owm_vld with we=0 -> RD_W.
  - RD_W: owm_rdy -> store byte[n], feed CRC, n++. n=9 -> CHK, otherwise RD.
  - CHK: one cycle. If CRC == 0: temp <= {byte1,byte0}, temp_vld <= 1. Else crc_err <= 1. -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Error flags are cleared on accepted start.
- start asserted while busy is ignored. start asserted in the FIN cycle is also ignored.
- CRC: Dallas poly x^8+x^5+x^4+1, LSB-first (reflected 0x8C), init 0x00.
  - One byte per update, registered, 1-cycle latency.
  - A CHK entered on the cycle after the last update uses the updated value.
- Counters: CONV counter $clog2(CONV_CYC+1) bits; timeout counter $clog2(XFER_TO+1) bits; byte index 4 bits, saturating at 9.
- arst_n low mid-sequence: return to IDLE immediately, all outputs to reset values. temp and temp_vld are also cleared. No done is emitted.

Decomposition:
- Package ds18b20_pkg:
  - command constants CMD_SKIP_ROM=8'hCC, CMD_CONVERT=8'h44, CMD_READ_SP=8'hBE, SP_BYTES=9;
  - state enum typedef;
  - function crc8_byte(crc, byte).
- Sub-module ds18b20_crc8: clear, update-enable, 8-bit data, registered crc output.

Test Plan:
1. Slave model returns scratchpad 50 05 4B 46 7F FF 0C 10 1C -> exactly two reset requests and write bytes CC,44,CC,BE in order. Gap between 44 and the second reset is ≥ CONV_CYC. done pulses once with temp=16'h0550, temp_vld=1, crc_err=0, to_err=0.
2. Same scratchpad with last byte 1D -> crc_err=1 with done; temp stays at its prior value (0 from reset); temp_vld=0.
3. Master model never raises owm_rdy after the first owm_vld -> to_err=1 and done exactly XFER_TO+2 cycles after that vld (±1). No further owm_vld is issued.
4. start re-pulsed every 10 cycles during a run -> only one sequence executes and only one done appears.
5. arst_n low during RD of byte 4 -> next cycle busy=0, owm_vld=0, owm_rst_n=1, temp=0. A following start runs a full clean sequence.
6. Two back-to-back runs, first with temp bytes 91 01 + valid CRC, second corrupted -> temp=16'h0191 after run 1 and unchanged after run 2; temp_vld remains 1.
